// File: rtl/rb_led_activity_if.sv
// System-bus register slice connecting a bus master to rb_led_activity.
interface rb_led_activity_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/rb_led_activity.sv
// RadioBox LED source: turns event strobes into off / on / blink / pulse-stretched activity patterns.
// Defining RB_LED_PWM_EN adds a BRIGHT register (0x18) that PWM-modulates every LED output.
module rb_led_activity #(
    parameter int DWL     = 8,
    parameter int CLK_DIV = 125000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [DWL-1:0]   evt_i,
    output logic             rb_led_en_o,
    output logic [DWL-1:0]   rb_led_d_o,
    rb_led_activity_if.slave bus
);
    localparam int MW = 2 * DWL;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    localparam logic [19:0] ADDR_CTRL    = 20'h00;
    localparam logic [19:0] ADDR_MODE    = 20'h04;
    localparam logic [19:0] ADDR_BLINK   = 20'h08;
    localparam logic [19:0] ADDR_STRETCH = 20'h0C;
    localparam logic [19:0] ADDR_GAP     = 20'h10;
    localparam logic [19:0] ADDR_STATUS  = 20'h14;
    localparam logic [19:0] ADDR_BRIGHT  = 20'h18;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_ACT   = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [19:0]    addr;
    logic           wr_ctrl;
    logic           wr_mode;
    logic           wr_blink;
    logic           wr_stretch;
    logic           wr_gap;

    logic           ctrl_en;
    logic [MW-1:0]  mode_q;
    logic [15:0]    blink_half_q;
    logic [15:0]    stretch_q;
    logic [15:0]    gap_q;

    logic [PW-1:0]  presc;
    logic           tick;
    logic [15:0]    blink_cnt;
    logic [15:0]    blink_last;
    logic           blink_phase;
    logic [15:0]    stretch_len;
    logic [15:0]    gap_len;

    logic [DWL-1:0] act_on;
    logic [DWL-1:0] led_next;
    logic [DWL-1:0] led_mod;
    logic [31:0]    rd_mux;
    logic           rd_ack;
    logic [31:0]    rd_data;
    logic           unused_bus;

    // Byte selects are ignored (full-word writes only), upper address bits are not decoded.
    assign unused_bus = &{1'b0, bus.sys_sel, bus.sys_addr[31:20], bus.sys_wdata[31:16]};

    assign addr       = bus.sys_addr[19:0];
    assign wr_ctrl    = bus.sys_wen && (addr == ADDR_CTRL);
    assign wr_mode    = bus.sys_wen && (addr == ADDR_MODE);
    assign wr_blink   = bus.sys_wen && (addr == ADDR_BLINK);
    assign wr_stretch = bus.sys_wen && (addr == ADDR_STRETCH);
    assign wr_gap     = bus.sys_wen && (addr == ADDR_GAP);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_en      <= 1'b0;
            mode_q       <= '0;
            blink_half_q <= 16'd500;
            stretch_q    <= 16'd50;
            gap_q        <= 16'd50;
        end else begin
            if (wr_ctrl)    ctrl_en      <= bus.sys_wdata[0];
            if (wr_mode)    mode_q       <= bus.sys_wdata[MW-1:0];
            if (wr_blink)   blink_half_q <= bus.sys_wdata[15:0];
            if (wr_stretch) stretch_q    <= bus.sys_wdata[15:0];
            if (wr_gap)     gap_q        <= bus.sys_wdata[15:0];
        end
    end

    assign rb_led_en_o = ctrl_en;

`ifdef RB_LED_PWM_EN
    logic [7:0] bright_q;
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bright_q <= 8'hFF;
            pwm_cnt  <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (bus.sys_wen && (addr == ADDR_BRIGHT)) bright_q <= bus.sys_wdata[7:0];
        end
    end

    assign led_mod = led_next & {DWL{pwm_cnt < bright_q}};
`else
    assign led_mod = led_next;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            ADDR_CTRL:    rd_mux = {31'd0, ctrl_en};
            ADDR_MODE:    rd_mux = 32'(mode_q);
            ADDR_BLINK:   rd_mux = {16'd0, blink_half_q};
            ADDR_STRETCH: rd_mux = {16'd0, stretch_q};
            ADDR_GAP:     rd_mux = {16'd0, gap_q};
            ADDR_STATUS:  rd_mux = 32'(rb_led_d_o);
`ifdef RB_LED_PWM_EN
            ADDR_BRIGHT:  rd_mux = {24'd0, bright_q};
`endif
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ack  <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            rd_ack  <= bus.sys_wen | bus.sys_ren;
            rd_data <= bus.sys_ren ? rd_mux : 32'd0;
        end
    end

    assign bus.sys_ack   = rd_ack;
    assign bus.sys_rdata = rd_data;
    assign bus.sys_err   = 1'b0;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // A zero half-period behaves like one tick so the blink never stalls.
    assign blink_last = (blink_half_q == 16'd0) ? 16'd0 : blink_half_q - 16'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            blink_cnt   <= 16'd0;
            blink_phase <= 1'b0;
        end else if (wr_blink) begin
            blink_cnt   <= 16'd0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt >= blink_last) begin
                blink_cnt   <= 16'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    assign stretch_len = (stretch_q == 16'd0) ? 16'd1 : stretch_q;
    assign gap_len     = (gap_q == 16'd0) ? 16'd1 : gap_q;

    for (genvar i = 0; i < DWL; i++) begin : g_act
        logic [1:0]  state;
        logic [15:0] cnt;
        logic        pending;
        logic [1:0]  mode_i;

        assign mode_i    = mode_q[2*i +: 2];
        assign act_on[i] = (state == ST_ON);

        // An event arriving on the terminal GAP tick counts as pending, so it re-lights immediately.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state   <= ST_IDLE;
                cnt     <= 16'd0;
                pending <= 1'b0;
            end else if (mode_i != MODE_ACT) begin
                state   <= ST_IDLE;
                pending <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (evt_i[i]) begin
                            state <= ST_ON;
                            cnt   <= stretch_len;
                        end
                    end
                    ST_ON: begin
                        if (evt_i[i]) pending <= 1'b1;
                        if (tick) begin
                            if (cnt == 16'd1) begin
                                state <= ST_GAP;
                                cnt   <= gap_len;
                            end else begin
                                cnt <= cnt - 16'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick && (cnt == 16'd1)) begin
                            pending <= 1'b0;
                            if (pending || evt_i[i]) begin
                                state <= ST_ON;
                                cnt   <= stretch_len;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            if (evt_i[i]) pending <= 1'b1;
                            if (tick) cnt <= cnt - 16'd1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < DWL; i++) begin
            case (mode_q[2*i +: 2])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = blink_phase;
                default:    led_next[i] = act_on[i];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rb_led_d_o <= '0;
        end else begin
            rb_led_d_o <= led_mod;
        end
    end
endmodule
